leaf_stream_buffer: RTL and testbench

- Clocked downstream stage for the leaf inverter path. Accepts SIZE-bit words on a valid/ready input, optionally bit-inverts them, queues them in a DEPTH-entry FIFO, and presents them on a valid/ready output.
- Used by hierarchical-parameter tests. SIZE and DEPTH are set from the top level with defparam, for example defparam u_branch.u_buf.SIZE = 4, so that override propagation is exercised on sequential logic and not only on combinational logic.

---
 rtl/leaf_stream_mem.sv | 25 ++
 rtl/leaf_stream_buffer.sv | 86 ++++++++
 tb/tb_leaf_stream_buffer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/leaf_stream_mem.sv
// DEPTH x SIZE register array for the leaf stream buffer.
// It has one synchronous write port and one asynchronous read port. The storage has no reset.
module leaf_stream_mem #(
  parameter int SIZE  = 2,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [SIZE-1:0]            i_wr_data,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [SIZE-1:0]            o_rd_data
);

  logic [SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/leaf_stream_buffer.sv
// Valid/ready FIFO stage for the leaf inverter path. Words can be inverted on entry.
// SIZE and DEPTH are forwarded to the memory, so a hierarchical override reaches the storage.
module leaf_stream_buffer #(
  parameter int SIZE   = 2,
  parameter int DEPTH  = 4,
  parameter int INVERT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SIZE-1:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  function automatic integer f_clog2(input integer value);
    integer v;
    integer r;
    begin
      r = 0;
      v = value - 1;
      while (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
      f_clog2 = r;
    end
  endfunction

  localparam int           AW         = f_clog2(DEPTH);
  localparam logic [AW:0]  FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;
  logic [SIZE-1:0] w_wr_data;
  logic [SIZE-1:0] w_rd_data;

  // in_ready depends only on the registered count, so a full buffer never passes data straight through.
  assign in_ready  = (r_count != FULL_COUNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_wr_data = (INVERT != 0) ? ~in_data : in_data;
  assign out_data  = out_valid ? w_rd_data : '0;
  assign count     = r_count;

  leaf_stream_mem #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk     (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // The pointers wrap by natural overflow because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed bench for leaf_stream_buffer with SIZE=4, DEPTH=4 and inversion on.
// A queue model is checked on every falling edge, and literal checks pin the model.
module tb_leaf_stream_buffer;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq[$];

  leaf_stream_buffer #(
    .SIZE   (4),
    .DEPTH  (4),
    .INVERT (1)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs just after a falling edge. The next rising edge applies them.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  // Reference FIFO: a queue of stored words, bounded at four entries and cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      automatic bit doPop  = (mq.size() != 0) && out_ready;
      automatic bit doPush = in_valid && (mq.size() < 4);
      if (doPop) void'(mq.pop_front());
      if (doPush) mq.push_back(~in_data);
    end
  end

  always @(negedge clk) begin
    automatic int         n   = mq.size();
    automatic logic [3:0] exp = (n != 0) ? mq[0] : 4'h0;
    checkOutput("cmpOutValid", {31'd0, out_valid}, {31'd0, n != 0});
    checkOutput("cmpOutData", {28'd0, out_data}, {28'd0, exp});
    checkOutput("cmpInReady", {31'd0, in_ready}, {31'd0, n != 4});
    checkOutput("cmpCount", {29'd0, count}, n);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstOutValid", {31'd0, out_valid}, 0);
    checkOutput("rstOutData", {28'd0, out_data}, 0);
    checkOutput("rstInReady", {31'd0, in_ready}, 1);
    checkOutput("rstCount", {29'd0, count}, 0);
    checkOutput("dataWidth", $bits(out_data), 4);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word
    applyStimulus(1'b1, 4'hA, 1'b0);
    afterEdge();
    checkOutput("singleValid", {31'd0, out_valid}, 1);
    checkOutput("singleData", {28'd0, out_data}, 4'h5);
    applyStimulus(1'b0, 4'h0, 1'b1);
    afterEdge();
    checkOutput("singlePopValid", {31'd0, out_valid}, 0);
    checkOutput("singlePopCount", {29'd0, count}, 0);

    // Fill, then offer a fifth word while full
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 4'(i), 1'b0);
    afterEdge();
    checkOutput("fullCount", {29'd0, count}, 4);
    checkOutput("fullInReady", {31'd0, in_ready}, 0);
    checkOutput("fullHead", {28'd0, out_data}, 4'hE);

    // Push and pop while full: the pop happens and the push is refused
    applyStimulus(1'b1, 4'h7, 1'b1);
    afterEdge();
    checkOutput("fullPopCount", {29'd0, count}, 3);
    checkOutput("fullPopInReady", {31'd0, in_ready}, 1);
    checkOutput("fullPopHead", {28'd0, out_data}, 4'hD);
    applyStimulus(1'b1, 4'h6, 1'b0);
    afterEdge();
    checkOutput("refillCount", {29'd0, count}, 4);
    applyStimulus(1'b0, 4'h0, 1'b1);
    afterEdge();
    checkOutput("drain1", {28'd0, out_data}, 4'hC);
    applyStimulus(1'b0, 4'h0, 1'b1);
    afterEdge();
    checkOutput("drain2", {28'd0, out_data}, 4'hB);
    applyStimulus(1'b0, 4'h0, 1'b1);
    afterEdge();
    checkOutput("drain3", {28'd0, out_data}, 4'h9);
    applyStimulus(1'b0, 4'h0, 1'b1);
    afterEdge();
    checkOutput("drainEmpty", {31'd0, out_valid}, 0);

    // Wrap-around streaming
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b1);
      afterEdge();
      checkOutput("streamCount", {29'd0, count}, 1);
      checkOutput("streamData", {28'd0, out_data}, {28'd0, ~4'(i)});
    end

    // Reach count = 3, then reset asynchronously between edges
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    afterEdge();
    checkOutput("preRstCount", {29'd0, count}, 3);
    checkOutput("preRstHead", {28'd0, out_data}, 4'h6);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, out_valid}, 0);
    checkOutput("midRstCount", {29'd0, count}, 0);
    checkOutput("midRstData", {28'd0, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'h0, 1'b0);
    afterEdge();
    checkOutput("postRstData", {28'd0, out_data}, 4'hF);
    checkOutput("postRstCount", {29'd0, count}, 1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    afterEdge();
    checkOutput("finalCount", {29'd0, count}, 0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
